// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 -- eight-requester round-robin arbiter with bounded hold.
//
// Selects one requester, presents it encoded (grant_idx) and one-hot
// (grant), and keeps the grant until the owner asserts done, drops its
// request, or has held for HOLD_MAX cycles. A released requester gets
// lowest priority for the next arbitration. Every grant is followed by
// at least one idle cycle.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req[7:0]     in   request vector, bit i = requester i
//   done         in   current owner finished (only looked at while granting)
//   grant[7:0]   out  one-hot grant, 8'h00 when no grant is active
//   grant_idx    out  encoded owner, holds its last value when not valid
//   grant_valid  out  a grant is active
//   timeout      out  one-cycle pulse on a forced release at HOLD_MAX
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; arbitrate on the next edge if any req is set
// S_GRANT | grant_idx owns the resource; watch done / req drop / hold
module rr_arbiter_8 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  logic       grant_valid_q, grant_valid_d;
  logic       timeout_q, timeout_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] scan_idx;
  logic       rel_done;
  logic       rel_drop;
  logic       rel_hold;
  logic       release_now;

  // Rotating priority scan: ptr first, then ptr+1, ... wrapping mod 8.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int i = 0; i < 8; i++) begin
      scan_idx = ptr_q + 3'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    rel_done    = done;
    rel_drop    = ~req[grant_idx_q];
    rel_hold    = (cnt_q == HOLD_MAX_C);
    release_now = rel_done | rel_drop | rel_hold;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d       = S_GRANT;
          grant_idx_d   = win_idx;
          grant_d       = 8'b1 << win_idx;
          grant_valid_d = 1'b1;
          cnt_d         = 8'd1;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          state_d       = S_IDLE;
          grant_d       = 8'h00;
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + 3'd1;
          cnt_d         = 8'd0;
          // done takes precedence: a voluntary release is never a timeout
          timeout_d     = rel_hold & ~rel_done;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= 3'd0;
      cnt_q         <= 8'd0;
      grant_q       <= 8'h00;
      grant_idx_q   <= 3'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int total;
  int bad;

  rr_arbiter_8 #(.HOLD_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                         input logic v, input logic t);
    chk({tag, ".grant"},       32'(grant),       32'(g));
    chk({tag, ".grant_idx"},   32'(grant_idx),   32'(idx));
    chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(v));
    chk({tag, ".timeout"},     32'(timeout),     32'(t));
  endtask

  // grant must be zero or one-hot in every cycle
  always @(negedge clk) begin
    total++;
    assert (($countones(grant) <= 1) === 1'b1) else begin
      bad++;
      $error("FAIL onehot observed=%0h expected=at_most_one_bit", grant);
    end
  end

  initial begin
    logic [7:0] seen;
    logic [7:0] exp_g;

    // reset held with all requests asserted
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    #1;
    chk_out("reset0", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    step();
    chk_out("reset2", 8'h00, 3'd0, 1'b0, 1'b0);

    rst_n = 1'b1;
    req   = 8'h00;
    step();
    chk_out("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

    // single requester 5
    req = 8'h20;
    step();
    chk_out("single_g1", 8'h20, 3'd5, 1'b1, 1'b0);
    step();
    chk_out("single_g2", 8'h20, 3'd5, 1'b1, 1'b0);
    step();
    chk_out("single_g3", 8'h20, 3'd5, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_out("single_rel", 8'h00, 3'd5, 1'b0, 1'b0);
    done = 1'b0;
    step();
    chk_out("single_regrant", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk_out("single_drop", 8'h00, 3'd5, 1'b0, 1'b0);

    // wrap: serve 6, then req 41 -> 0 then 6
    req = 8'h40;
    step();
    chk_out("wrap_g6", 8'h40, 3'd6, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_out("wrap_rel6", 8'h00, 3'd6, 1'b0, 1'b0);
    done = 1'b0;
    req  = 8'h41;
    step();
    chk_out("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_out("wrap_rel0", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    step();
    chk_out("wrap_g6b", 8'h40, 3'd6, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_out("wrap_rel6b", 8'h00, 3'd6, 1'b0, 1'b0);
    done = 1'b0;
    req  = 8'h00;

    // timeout with HOLD_MAX = 4 on requester 3
    req = 8'h08;
    step();
    chk_out("to_c1", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_out("to_c2", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_out("to_c3", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_out("to_c4", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_out("to_pulse", 8'h00, 3'd3, 1'b0, 1'b1);
    step();
    chk_out("to_regrant", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_out("to2_c2", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_out("to2_c3", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_out("to2_c4", 8'h08, 3'd3, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_out("to2_done_wins", 8'h00, 3'd3, 1'b0, 1'b0);
    done = 1'b0;
    req  = 8'h00;
    step();
    chk_out("to2_idle", 8'h00, 3'd3, 1'b0, 1'b0);

    // request drop: grant 2, other bits ignored, drop req[2] with req[7] set
    req = 8'h04;
    step();
    chk_out("drop_g2", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h84;
    step();
    chk_out("drop_hold", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h80;
    step();
    chk_out("drop_rel", 8'h00, 3'd2, 1'b0, 1'b0);
    step();
    chk_out("drop_g7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk_out("drop_rel7", 8'h00, 3'd7, 1'b0, 1'b0);

    // full round-robin, pointer is back at 0
    req  = 8'hFF;
    seen = 8'h00;
    for (int i = 0; i < 9; i++) begin
      exp_g = 8'h01 << (i % 8);
      step();
      chk($sformatf("rr_grant%0d", i), 32'(grant), 32'(exp_g));
      chk($sformatf("rr_valid%0d", i), 32'(grant_valid), 32'd1);
      if (i < 8) begin
        chk($sformatf("rr_norepeat%0d", i), 32'(seen & grant), 32'd0);
        seen = seen | grant;
      end
      done = 1'b1;
      step();
      chk($sformatf("rr_gap%0d", i), 32'({grant_valid, grant}), 32'd0);
      done = 1'b0;
    end
    chk("rr_all_served", 32'(seen), 32'hFF);

    // reset in the middle of a grant
    step();
    chk_out("mid_g1", 8'h02, 3'd1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid_async", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("mid_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk_out("mid_rel", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
